// File: rtl/immgen_pkg.sv
// immgen_pkg: immediate format codes and base opcodes shared by the immediate-generation stage
package immgen_pkg;
   typedef enum logic [2:0] {
      FMT_NONE = 3'd0, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z
   } imm_fmt_e;
   localparam logic [6:0] OPC_OP_IMM    = 7'h13;
   localparam logic [6:0] OPC_LOAD      = 7'h03;
   localparam logic [6:0] OPC_JALR      = 7'h67;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
   localparam logic [6:0] OPC_STORE     = 7'h23;
   localparam logic [6:0] OPC_BRANCH    = 7'h63;
   localparam logic [6:0] OPC_LUI       = 7'h37;
   localparam logic [6:0] OPC_AUIPC     = 7'h17;
   localparam logic [6:0] OPC_JAL       = 7'h6F;
   localparam logic [6:0] OPC_SYSTEM    = 7'h73;
endpackage

// File: rtl/imm_extract.sv
// imm_extract: classifies an instruction's immediate format and extends it to XLEN; CSR-immediate via IMMGEN_PIPE_ZICSR_EN
module imm_extract import immgen_pkg::*; #(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output imm_fmt_e        fmt,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);
   logic [6:0] opc;
   logic       sh;
   logic [5:0] shamt;
   assign opc = instr[6:0];
   assign sh = instr[13:12] == 2'b01;
   // RV64 OP-IMM shifts use a 6-bit shamt; word shifts and RV32 keep 5 bits so funct7 never leaks
   assign shamt = (XLEN == 64 && opc == OPC_OP_IMM) ? instr[25:20] : {1'b0, instr[24:20]};
   always_comb begin
      fmt = FMT_NONE;
      case (opc)
         OPC_OP_IMM:         fmt = sh ? FMT_SH : FMT_I;
         OPC_LOAD, OPC_JALR: fmt = FMT_I;
         OPC_OP_IMM_32:      fmt = XLEN == 64 ? (sh ? FMT_SH : FMT_I) : FMT_NONE;
         OPC_STORE:          fmt = FMT_S;
         OPC_BRANCH:         fmt = FMT_B;
         OPC_LUI, OPC_AUIPC: fmt = FMT_U;
         OPC_JAL:            fmt = FMT_J;
`ifdef IMMGEN_PIPE_ZICSR_EN
         OPC_SYSTEM:         fmt = instr[14] ? FMT_Z : FMT_NONE;
`endif
         default:            fmt = FMT_NONE;
      endcase
   end
   always_comb begin
      imm = '0;
      case (fmt)
         FMT_I:   imm = XLEN'($signed(instr[31:20]));
         FMT_SH:  imm = XLEN'(shamt);
         FMT_S:   imm = XLEN'($signed({instr[31:25], instr[11:7]}));
         FMT_B:   imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
         FMT_U:   imm = XLEN'($signed({instr[31:12], 12'b0}));
         FMT_J:   imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
         FMT_Z:   imm = XLEN'(instr[19:15]);
         default: imm = '0;
      endcase
   end
   assign illegal = fmt == FMT_NONE;
endmodule

// File: rtl/immgen_pipe.sv
// immgen_pipe: registered immediate generation with a 2-entry skid buffer; CSR-immediate via IMMGEN_PIPE_ZICSR_EN
module immgen_pipe import immgen_pkg::*; #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output imm_fmt_e         out_fmt,
   output logic             out_illegal,
   output logic [31:0]      out_instr,
   output logic [TAG_W-1:0] out_tag
);
   typedef struct packed {
      logic [XLEN-1:0]  imm;
      imm_fmt_e         fmt;
      logic             illegal;
      logic [31:0]      instr;
      logic [TAG_W-1:0] tag;
   } entry_t;
   entry_t          out_q, out_d, skid_q, skid_d, new_e;
   logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
   logic            acc, drain;
   imm_fmt_e        ext_fmt;
   logic [XLEN-1:0] ext_imm;
   logic            ext_illegal;
   imm_extract #(.XLEN(XLEN)) u_ext (
      .instr   (in_instr),
      .fmt     (ext_fmt),
      .imm     (ext_imm),
      .illegal (ext_illegal)
   );
   assign in_ready = !skid_valid_q && !rst;
   assign acc = in_valid && in_ready;
   assign drain = out_valid_q && out_ready && !rst;
   always_comb begin
      new_e = '{imm: ext_imm, fmt: ext_fmt, illegal: ext_illegal, instr: in_instr, tag: in_tag};
      out_valid_d = out_valid_q;
      skid_valid_d = skid_valid_q;
      out_d = out_q;
      skid_d = skid_q;
      if (drain) begin
         out_valid_d = skid_valid_q;
         out_d = skid_valid_q ? skid_q : out_q;
         skid_valid_d = 1'b0;
      end
      // accept and skid-full are exclusive, so a drained slot is always free for the new word
      if (acc) begin
         if (!out_valid_q || drain) begin
            out_valid_d = 1'b1;
            out_d = new_e;
         end else begin
            skid_valid_d = 1'b1;
            skid_d = new_e;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         out_q <= '0;
         skid_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         out_q <= out_d;
         skid_q <= skid_d;
      end
   end
   assign out_valid = out_valid_q && !rst;
   assign out_imm = out_q.imm;
   assign out_fmt = out_q.fmt;
   assign out_illegal = out_q.illegal;
   assign out_instr = out_q.instr;
   assign out_tag = out_q.tag;
endmodule

// File: tb/tb_immgen_pipe.sv
// tb_immgen_pipe: directed checks of immgen_pipe at XLEN 32 and 64 side by side
module tb_immgen_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic [31:0] in_tag = '0;
   logic        out_ready = 1'b1;
   logic        rdy32, ov32, ill32, rdy64, ov64, ill64;
   logic [31:0] imm32, ins32, tag32, ins64, tag64;
   logic [63:0] imm64;
   logic [2:0]  fmt32, fmt64;
   int n_assert = 0;
   int n_fail = 0;
`ifdef IMMGEN_PIPE_ZICSR_EN
   localparam logic [63:0] Z_IMM = 64'd5;
   localparam logic [2:0]  Z_FMT = 3'd7;
`else
   localparam logic [63:0] Z_IMM = 64'd0;
   localparam logic [2:0]  Z_FMT = 3'd0;
`endif
   immgen_pipe #(.XLEN(32), .TAG_W(32)) d32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr),
      .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32),
      .out_fmt(fmt32), .out_illegal(ill32), .out_instr(ins32), .out_tag(tag32)
   );
   immgen_pipe #(.XLEN(64), .TAG_W(32)) d64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
      .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64),
      .out_fmt(fmt64), .out_illegal(ill64), .out_instr(ins64), .out_tag(tag64)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   logic [31:0] v_ins [10];
   logic [63:0] v_i32 [10];
   logic [63:0] v_i64 [10];
   logic [2:0]  v_f32 [10];
   logic [2:0]  v_f64 [10];
   initial begin
      v_ins[0] = 32'h00500013; v_i32[0] = 64'h5;        v_f32[0] = 3'd1; v_i64[0] = 64'h5;                v_f64[0] = 3'd1;
      v_ins[1] = 32'h4030D093; v_i32[1] = 64'h3;        v_f32[1] = 3'd2; v_i64[1] = 64'h3;                v_f64[1] = 3'd2;
      v_ins[2] = 32'hFE0008E3; v_i32[2] = 64'hFFFFFFF0; v_f32[2] = 3'd4; v_i64[2] = 64'hFFFFFFFFFFFFFFF0; v_f64[2] = 3'd4;
      v_ins[3] = 32'h801FF06F; v_i32[3] = 64'hFFFFF800; v_f32[3] = 3'd6; v_i64[3] = 64'hFFFFFFFFFFFFF800; v_f64[3] = 3'd6;
      v_ins[4] = 32'hABCDE037; v_i32[4] = 64'hABCDE000; v_f32[4] = 3'd5; v_i64[4] = 64'hFFFFFFFFABCDE000; v_f64[4] = 3'd5;
      v_ins[5] = 32'hFE002823; v_i32[5] = 64'hFFFFFFF0; v_f32[5] = 3'd3; v_i64[5] = 64'hFFFFFFFFFFFFFFF0; v_f64[5] = 3'd3;
      v_ins[6] = 32'h03F01013; v_i32[6] = 64'h1F;       v_f32[6] = 3'd2; v_i64[6] = 64'h3F;               v_f64[6] = 3'd2;
      v_ins[7] = 32'h0250101B; v_i32[7] = 64'h0;        v_f32[7] = 3'd0; v_i64[7] = 64'h5;                v_f64[7] = 3'd2;
      v_ins[8] = 32'h0000007F; v_i32[8] = 64'h0;        v_f32[8] = 3'd0; v_i64[8] = 64'h0;                v_f64[8] = 3'd0;
      v_ins[9] = 32'h3002D073; v_i32[9] = Z_IMM;        v_f32[9] = Z_FMT; v_i64[9] = Z_IMM;               v_f64[9] = Z_FMT;
      repeat (2) step();
      chk("rst in_ready32", rdy32, 0);
      chk("rst in_ready64", rdy64, 0);
      chk("rst out_valid", ov32, 0);
      chk("rst imm", imm32, 0);
      chk("rst fmt", fmt32, 0);
      chk("rst illegal", ill32, 0);
      chk("rst instr", ins32, 0);
      chk("rst tag", tag32, 0);
      rst = 1'b0;
      #1;
      chk("post-rst in_ready32", rdy32, 1);
      chk("post-rst in_ready64", rdy64, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_instr = v_ins[i];
         in_tag = 32'(100 + i);
         step();
         chk($sformatf("stream%0d valid", i), ov32, 1);
         chk($sformatf("stream%0d imm32", i), imm32, v_i32[i]);
         chk($sformatf("stream%0d fmt32", i), fmt32, v_f32[i]);
         chk($sformatf("stream%0d ill32", i), ill32, v_f32[i] == 3'd0);
         chk($sformatf("stream%0d instr32", i), ins32, v_ins[i]);
         chk($sformatf("stream%0d tag32", i), tag32, 100 + i);
         chk($sformatf("stream%0d imm64", i), imm64, v_i64[i]);
         chk($sformatf("stream%0d fmt64", i), fmt64, v_f64[i]);
         chk($sformatf("stream%0d ill64", i), ill64, v_f64[i] == 3'd0);
         chk($sformatf("stream%0d tag64", i), tag64, 100 + i);
      end
      in_valid = 1'b0;
      step();
      chk("stream drained", ov32, 0);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_instr = v_ins[0];
      in_tag = 32'd1;
      step();
      chk("bp t1 valid", ov32, 1);
      chk("bp t1 tag", tag32, 1);
      chk("bp t1 ready", rdy32, 1);
      in_instr = v_ins[2];
      in_tag = 32'd2;
      step();
      chk("bp skid tag", tag32, 1);
      chk("bp skid ready", rdy32, 0);
      in_instr = v_ins[3];
      in_tag = 32'd3;
      step();
      chk("bp hold tag", tag32, 1);
      chk("bp hold imm", imm32, 64'h5);
      chk("bp hold ready", rdy32, 0);
      out_ready = 1'b1;
      step();
      chk("bp out2 valid", ov32, 1);
      chk("bp out2 tag", tag32, 2);
      chk("bp out2 imm", imm32, 64'hFFFFFFF0);
      chk("bp out2 ready", rdy32, 1);
      step();
      chk("bp out3 valid", ov32, 1);
      chk("bp out3 tag", tag32, 3);
      chk("bp out3 imm", imm32, 64'hFFFFF800);
      in_valid = 1'b0;
      step();
      chk("bp empty", ov32, 0);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_tag = 32'd40;
      step();
      in_tag = 32'd41;
      step();
      chk("full ready", rdy32, 0);
      rst = 1'b1;
      in_tag = 32'd42;
      #1;
      chk("rst-cycle valid", ov32, 0);
      chk("rst-cycle ready", rdy32, 0);
      @(posedge clk);
      #1;
      chk("after-rst valid", ov32, 0);
      chk("after-rst ready", rdy32, 0);
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("release ready", rdy32, 1);
      chk("release valid", ov32, 0);
      step();
      chk("no stale valid", ov32, 0);
      chk("no stale valid64", ov64, 0);
      in_valid = 1'b1;
      in_instr = v_ins[4];
      in_tag = 32'd77;
      step();
      in_valid = 1'b0;
      chk("restart valid", ov32, 1);
      chk("restart tag", tag32, 77);
      chk("restart imm64", imm64, 64'hFFFFFFFFABCDE000);
      step();
      chk("restart drained", ov32, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/immgen_pipe.md
# immgen_pipe

- Registered, parametrised immediate-generation stage for the decode path.
- Accepts 32-bit instruction words over a valid/ready handshake.
- Classifies each word's immediate format and produces the immediate sign- or zero-extended to XLEN.
- Sits between fetch and register-read in the pipelined successor to the single-cycle core, with a 2-entry skid buffer so `in_ready` is purely registered.

## Interface
- `XLEN`, default 32: datapath width; legal values 32 or 64.
- `TAG_W`, default 32: width of the sideband tag (PC) carried alongside each instruction.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: `in_instr` and `in_tag` are valid.
- `in_ready`  out  1: stage can accept; depends only on registered state and `rst`.
- `in_instr`  in  32: instruction word.
- `in_tag`  in  TAG_W: passed through unchanged.
- `out_valid`  out  1: output fields are valid.
- `out_ready`  in  1: downstream accepts.
- `out_imm`  out  XLEN: extended immediate.
- `out_fmt`  out  3: `imm_fmt_e` code.
- `out_illegal`  out  1: opcode has no recognised format.
- `out_instr`  out  32: the original word, forwarded.
- `out_tag`  out  TAG_W: the forwarded tag.

## Operation
- **Opcode to format:**
  - 0x13 with funct3 001/101 → FMT_SH; other 0x13, plus 0x03 and 0x67 → FMT_I.
  - 0x1B (XLEN=64 only): funct3 001/101 → FMT_SH, else FMT_I.
  - 0x23 → FMT_S; 0x63 → FMT_B; 0x37 and 0x17 → FMT_U; 0x6F → FMT_J.
- **Immediate rules:**
  - I: instr[31:20]; S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}; J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - I, S, B, U and J all sign-extend from instr[31] to XLEN; U sign-extends from bit 31 when XLEN=64.
  - FMT_SH: shamt zero-extended, never sign-extended. The shamt is instr[24:20] when XLEN=32; instr[25:20] for 0x13 when XLEN=64; instr[24:20] for 0x1B. funct7 bits never leak into `out_imm`.
- **Unrecognised opcode:** FMT_NONE, `out_imm`=0, `out_illegal`=1. All other formats give `out_illegal`=0.
- **Buffering:** one output register plus one skid register.
  - Accept = `in_valid && in_ready`.
  - An accepted word goes to the output register if it is empty or being drained that cycle, otherwise to the skid register.
  - On an output handshake with skid full, skid moves to the output register.
- `in_ready` = !skid_valid && !rst.
- Strict FIFO order; no word dropped or duplicated.
- Output fields are held stable while `out_valid && !out_ready`.

## Timing
- **Latency:** 1 cycle. A word accepted at edge N is visible on the outputs after edge N when the stage is empty.
- **Throughput:** 1 word/cycle with `out_ready` held high.
- **Reset values:** `out_valid`=0, `in_ready`=0 while `rst` is high, skid empty.
  - Data outputs: `out_imm`=0, `out_fmt`=FMT_NONE, `out_illegal`=0, `out_instr`=0, `out_tag`=0.
  - `in_ready`=1 in the first cycle after `rst` deasserts.
- **Reset mid-operation:** both entries are discarded and no handshake completes in the reset cycle.
- **Stall:** with `out_valid=1`, `out_ready=0`, a further accept fills the skid and `in_ready` falls after that edge.
- **Simultaneous accept and drain:**
  - Skid empty: the output register loads the new word, occupancy unchanged.
  - Skid full: accept is impossible because `in_ready`=0.

## Configuration
- `IMMGEN_PIPE_ZICSR_EN` defined:
  - Opcode 0x73 with funct3[2]=1 → FMT_Z.
  - `out_imm` = instr[19:15] zero-extended; `out_illegal`=0.
- `IMMGEN_PIPE_ZICSR_EN` undefined: those encodings are FMT_NONE, `out_imm`=0, `out_illegal`=1.

## Structure
- **Package `immgen_pkg`:**
  - Type `imm_fmt_e`, 3 bits: FMT_NONE=0, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z.
  - Opcode localparams (OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_OP_IMM_32, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM).
- **Sub-module `imm_extract`:** combinational, parametrised by XLEN; instr in, fmt/imm/illegal out.
- **Top level:** the handshake and skid registers.

## Test plan
- XLEN=32, streaming, `out_ready`=1:
  - 0x00500013 → imm 0x00000005, FMT_I.
  - 0x4030D093 (srai) → imm 0x00000003, FMT_SH.
  - 0xFE0008E3 → imm 0xFFFFFFF0, FMT_B.
  - 0x801FF06F → imm 0xFFFFF800, FMT_J.
  - One result per cycle, 1-cycle latency.
- XLEN=64:
  - 0xABCDE037 → imm 0xFFFFFFFFABCDE000, FMT_U.
  - 0xFE002823 → imm 0xFFFFFFFFFFFFFFF0, FMT_S.
  - 0x03F01013 → imm 0x3F, FMT_SH.
- Backpressure:
  - With `out_ready`=0, send tags 1, 2, 3.
  - Tag 1 is held at the output, tag 2 fills the skid, `in_ready`=0, tag 3 is held off.
  - Release `out_ready` → tags 1, 2, 3 emerge in order on consecutive handshakes.
- 0x3002D073 (csrrwi):
  - With macro defined → imm 5, FMT_Z, illegal 0.
  - Without macro → imm 0, FMT_NONE, illegal 1.
- Unknown opcode 0x0000007F → FMT_NONE, imm 0, illegal 1.
- Assert `rst` with both entries full:
  - Next cycle `out_valid`=0 and `in_ready`=0.
  - After `rst` deasserts, `in_ready`=1 and nothing stale is emitted.
